// File: rtl/teachee_defs.sv
// Shared definitions for the XADC sample packer: state encoding, header byte, frame lengths.
// No logic; compile-time constants only.
// Optional feature macro: XADC_PACKET_CHECKSUM_EN adds the SEND_CSUM state.
package teachee_defs;

  localparam logic [7:0] XADC_PACKET_HEADER  = 8'hA5;
  localparam int         XADC_FRAME_LEN      = 6;
  localparam int         XADC_FRAME_LEN_CSUM = 7;

  typedef enum logic [2:0] {
    IDLE,
    SEND_HEADER,
    SEND_SEQ,
    SEND_V_HI,
    SEND_V_LO,
    SEND_I_HI,
    SEND_I_LO
`ifdef XADC_PACKET_CHECKSUM_EN
    , SEND_CSUM
`endif
  } packer_state_e;

endpackage

// File: rtl/axis_interface.sv
// Minimal AXI-Stream bundle (tdata/tvalid/tready/tlast) with source and sink views.
// Latency: none, wires only.
// Backpressure: standard tvalid/tready handshake, transfer on tvalid && tready.
interface axis_interface #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport Source (output tdata, output tvalid, output tlast, input tready);
  modport Sink   (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/xadc_sample_hold.sv
// One-entry holding register for a 16-bit sample with a valid flag.
// Latency: sample is held from the cycle after tvalid && tready.
// Backpressure: tready = !valid, so the slot stays full until the packer clears it.
module xadc_sample_hold (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        tvalid_i,
  input  logic [15:0] tdata_i,
  output logic        tready_o,
  output logic        valid_nxt_o,
  output logic [15:0] data_o
);
  logic        valid_q, valid_d;
  logic [15:0] data_q, data_d;
  logic        capture;

  // Capture when empty; clear only happens while full, so the two never collide.
  always_comb begin
    capture = tvalid_i && !valid_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (capture) begin
      valid_d = 1'b1;
      data_d  = tdata_i;
    end
    if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= 16'h0000;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign tready_o    = !valid_q;
  assign valid_nxt_o = valid_d;
  assign data_o      = data_q;
endmodule

// File: rtl/xadc_sample_packer.sv
// Packs one voltage and one current sample into a byte frame: HDR, seq, V hi/lo, I hi/lo [, csum].
// Latency: header is valid the cycle after both samples are held; one IDLE cycle between frames.
// Backpressure: packet_stream stalls hold the current byte; sinks stall while their slot is full.
// Optional: define XADC_PACKET_CHECKSUM_EN to append a mod-256 checksum byte.
module xadc_sample_packer
  import teachee_defs::*;
#(
  parameter logic [7:0] HEADER_BYTE = XADC_PACKET_HEADER
) (
  input  logic          xadc_dclk,
  input  logic          xadc_reset,
  axis_interface.Sink   voltage_channel,
  axis_interface.Sink   current_monitor_channel,
  axis_interface.Source packet_stream
);
  packer_state_e state_q, state_d;
  logic [7:0]    seq_q, seq_d;
  logic          v_rdy, i_rdy, v_vld_nxt, i_vld_nxt;
  logic [15:0]   v_dat, i_dat;
  logic          frame_done;
  logic          out_vld, out_last, out_rdy;
  logic [7:0]    out_dat;

  xadc_sample_hold u_v_hold (
    .clk_i       (xadc_dclk),
    .rst_i       (xadc_reset),
    .clr_i       (frame_done),
    .tvalid_i    (voltage_channel.tvalid),
    .tdata_i     (voltage_channel.tdata),
    .tready_o    (v_rdy),
    .valid_nxt_o (v_vld_nxt),
    .data_o      (v_dat)
  );

  xadc_sample_hold u_i_hold (
    .clk_i       (xadc_dclk),
    .rst_i       (xadc_reset),
    .clr_i       (frame_done),
    .tvalid_i    (current_monitor_channel.tvalid),
    .tdata_i     (current_monitor_channel.tdata),
    .tready_o    (i_rdy),
    .valid_nxt_o (i_vld_nxt),
    .data_o      (i_dat)
  );

  assign out_rdy = packet_stream.tready;

`ifdef XADC_PACKET_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = HEADER_BYTE + seq_q + v_dat[15:8] + v_dat[7:0] + i_dat[15:8] + i_dat[7:0];
`endif

  // Byte sequencer: outputs are decoded from state so they stay stable during a stall.
  // IDLE looks at next-cycle valid flags so a capture and the IDLE exit share one edge.
  always_comb begin
    state_d    = state_q;
    out_vld    = 1'b1;
    out_last   = 1'b0;
    out_dat    = 8'h00;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        out_vld = 1'b0;
        if (v_vld_nxt && i_vld_nxt) state_d = SEND_HEADER;
      end
      SEND_HEADER: begin
        out_dat = HEADER_BYTE;
        if (out_rdy) state_d = SEND_SEQ;
      end
      SEND_SEQ: begin
        out_dat = seq_q;
        if (out_rdy) state_d = SEND_V_HI;
      end
      SEND_V_HI: begin
        out_dat = v_dat[15:8];
        if (out_rdy) state_d = SEND_V_LO;
      end
      SEND_V_LO: begin
        out_dat = v_dat[7:0];
        if (out_rdy) state_d = SEND_I_HI;
      end
      SEND_I_HI: begin
        out_dat = i_dat[15:8];
        if (out_rdy) state_d = SEND_I_LO;
      end
`ifdef XADC_PACKET_CHECKSUM_EN
      SEND_I_LO: begin
        out_dat = i_dat[7:0];
        if (out_rdy) state_d = SEND_CSUM;
      end
      SEND_CSUM: begin
        out_dat  = csum;
        out_last = 1'b1;
        if (out_rdy) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
`else
      SEND_I_LO: begin
        out_dat  = i_dat[7:0];
        out_last = 1'b1;
        if (out_rdy) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
`endif
      default: begin
        out_vld = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign seq_d = seq_q + {7'd0, frame_done};

  // State and frame sequence counter; reset abandons any frame in flight.
  always_ff @(posedge xadc_dclk) begin
    if (xadc_reset) begin
      state_q <= IDLE;
      seq_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
    end
  end

  assign packet_stream.tvalid          = out_vld;
  assign packet_stream.tdata           = out_dat;
  assign packet_stream.tlast           = out_last;
  assign voltage_channel.tready        = v_rdy;
  assign current_monitor_channel.tready = i_rdy;
endmodule

// File: doc/xadc_sample_packer.md
XADC_SAMPLE_PACKER -- requirements
Module: xadc_sample_packer

Interface
REQ-001 SHALL have parameter HEADER_BYTE, default 8'hA5, meaning the first byte of every frame.
REQ-002 SHALL have port xadc_dclk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port xadc_reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port voltage_channel  axis_interface.Sink  16  voltage samples from the DRP-to-AXIS adapter.
REQ-005 SHALL have port current_monitor_channel  axis_interface.Sink  16  current samples from the same adapter.
REQ-006 SHALL have port packet_stream  axis_interface.Source  8  byte frames with tlast toward the host FIFO.

Function
REQ-007 SHALL hold one voltage sample and one current sample in independent one-entry holding registers, each with a valid flag.
REQ-008 SHALL drive each sink tready = !(its valid flag), so capture occurs on tvalid && tready and the register stays full until its frame completes.
REQ-009 SHALL accept the two channels in either order or in the same cycle.
REQ-010 SHALL use states IDLE, SEND_HEADER, SEND_SEQ, SEND_V_HI, SEND_V_LO, SEND_I_HI, SEND_I_LO, plus SEND_CSUM when checksum is enabled.
REQ-011 SHALL leave IDLE for SEND_HEADER on the clock edge at which both valid flags are set; the header byte is presented with tvalid high in the following cycle.
REQ-012 SHALL advance one state per packet_stream tvalid && tready and SHALL hold tdata, tvalid and tlast stable while tvalid && !tready.
REQ-013 SHALL emit bytes in order HEADER_BYTE, seq[7:0], V[15:8], V[7:0], I[15:8], I[7:0], with tlast high only on the final byte of the frame.
REQ-014 SHALL increment the 8-bit sequence counter by one after each completed frame, wrapping 8'hFF -> 8'h00.
REQ-015 SHALL clear both valid flags on the cycle the final byte is accepted and return to IDLE; new samples may be captured from the next cycle.
REQ-016 SHALL keep packet_stream tvalid low in IDLE.
REQ-017 SHALL produce back-to-back frames with one IDLE cycle between them when both samples are already waiting.

Reset
REQ-018 SHALL on xadc_reset set state IDLE, both valid flags 0, sequence 8'h00, packet_stream tvalid 0, tlast 0, tdata 8'h00, and both sink treadys 1 in the cycle after reset.
REQ-019 SHALL abandon a partially sent frame on reset mid-frame, discard held samples, and begin the next frame at HEADER_BYTE with seq 8'h00.

Configuration
REQ-020 SHALL, when XADC_PACKET_CHECKSUM_EN is defined, append a seventh byte equal to the mod-256 sum of the six preceding frame bytes, with tlast on that byte only.
REQ-021 SHALL, when XADC_PACKET_CHECKSUM_EN is undefined, emit six-byte frames with tlast on I[7:0] and contain no checksum logic.

Structure
REQ-022 SHALL place the packer state enum typedef, XADC_PACKET_HEADER (8'hA5), and the frame-length constants (6 and 7) in teachee_defs.
REQ-023 SHALL implement each holding register as sub-module xadc_sample_hold (16-bit data, valid, tready), instantiated twice.

Verification
REQ-024 SHALL verify that voltage 16'h1234 followed 3 cycles later by current 16'h0567, with tready held at 1, produce bytes A5,00,12,34,05,67 (plus 57 with checksum), tlast on the last byte only.
REQ-025 SHALL verify that voltage and current presented in the same cycle are both accepted that cycle and the header appears exactly one cycle later.
REQ-026 SHALL verify that deasserting packet_stream tready for 5 cycles during V_LO keeps tdata=8'h34 and tvalid=1 stable, and that the frame then completes unchanged.
REQ-027 SHALL verify that a second voltage sample 16'hAAAA arriving mid-frame stalls (voltage tready=0) until the frame ends and is then sent in the frame with seq 01.
REQ-028 SHALL verify that after 256 frames the seq byte wraps to 8'h00.
REQ-029 SHALL verify that asserting xadc_reset during SEND_I_HI drops tvalid the next cycle and that the next frame starts A5,00.
